// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the hazard sequencer.
// Holds the register-number width, the hardwired zero register,
// the stall FSM state type and a register-match helper.
package pipeline_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hazard_state_t;

    // A dependence exists only on a real (nonzero) register number.
    function automatic logic reg_match(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] dst);
        return (src != ZERO_REG) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_detect.sv
// hazard_detect: combinational dependence check for the instruction in ID.
// Produces the number of bubbles needed before the ID instruction may
// proceed (0, 1 or 2). Also used by the ID-stage branch comparator checks.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_write_reg,
    output logic [1:0]       bubbles
);

    logic match_ex;
    logic match_mem;
    logic load_use;
    logic branch_alu;
    logic branch_load_ex;
    logic branch_load_mem;

    // Operand matches against the EX and MEM destinations; Rt counts only
    // when the ID instruction actually reads it.
    always_comb begin
        match_ex  = reg_match(id_rs, ex_write_reg) ||
                    (id_uses_rt && reg_match(id_rt, ex_write_reg));
        match_mem = reg_match(id_rs, mem_write_reg) ||
                    (id_uses_rt && reg_match(id_rt, mem_write_reg));
    end

    // Classify the hazard and take the largest bubble requirement.
    always_comb begin
        load_use        = ex_mem_read && match_ex;
        branch_alu      = id_branch && ex_reg_write && !ex_mem_read && match_ex;
        branch_load_ex  = id_branch && ex_mem_read && match_ex;
        branch_load_mem = id_branch && mem_mem_read && match_mem;

        bubbles = 2'd0;
        if (branch_load_ex) begin
            bubbles = 2'd2;
        end else if (load_use || branch_alu || branch_load_mem) begin
            bubbles = 2'd1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline hazard sequencer for the 5-stage MIPS core.
// Stalls PC and IF/ID, injects ID/EX bubbles for load-use and branch
// operand hazards, and flushes IF/ID on taken branches.
// Optional feature macro: HAZ_MULDIV_EN (multi-cycle mult/div busy tracking).
module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_Ex_MemRead,
    input  logic             ID_Ex_Regwrite,
    input  logic [REG_W-1:0] ID_Ex_WriteReg,
    input  logic             EX_MemMemRead,
    input  logic [REG_W-1:0] EX_MemWriteReg,
    input  logic             BranchTaken,
`ifdef HAZ_MULDIV_EN
    input  logic             ID_MulDiv,
    input  logic             ID_ReadsHiLo,
`endif
    output logic             PCWrite,
    output logic             IF_IDWrite,
    output logic             IF_IDFlush,
    output logic             ID_ExFlush,
    output logic [CNT_W-1:0] StallCycles
);

    hazard_state_t state;
    hazard_state_t next_state;
    logic [1:0]    bub_cnt;
    logic [1:0]    next_bub_cnt;
    logic [1:0]    bubbles;
    logic          fsm_stall;
    logic          busy_stall;
    logic          stall_any;

    hazard_detect u_detect (
        .id_rs         (ID_Rs),
        .id_rt         (ID_Rt),
        .id_uses_rt    (ID_UsesRt),
        .id_branch     (ID_Branch),
        .ex_mem_read   (ID_Ex_MemRead),
        .ex_reg_write  (ID_Ex_Regwrite),
        .ex_write_reg  (ID_Ex_WriteReg),
        .mem_mem_read  (EX_MemMemRead),
        .mem_write_reg (EX_MemWriteReg),
        .bubbles       (bubbles)
    );

    // FSM state and extra-bubble counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            bub_cnt <= 2'd0;
        end else begin
            state   <= next_state;
            bub_cnt <= next_bub_cnt;
        end
    end

    // RUN evaluates hazards; a 2-bubble hazard parks in HOLD for the extra
    // cycle without re-evaluating, since the producer is still in flight.
    always_comb begin
        next_state   = state;
        next_bub_cnt = bub_cnt;
        fsm_stall    = 1'b0;
        case (state)
            RUN: begin
                if (bubbles != 2'd0) begin
                    fsm_stall = 1'b1;
                    if (bubbles == 2'd2) begin
                        next_bub_cnt = 2'd1;
                        next_state   = HOLD;
                    end
                end
            end
            HOLD: begin
                fsm_stall    = 1'b1;
                next_bub_cnt = bub_cnt - 2'd1;
                if (bub_cnt <= 2'd1) begin
                    next_bub_cnt = 2'd0;
                    next_state   = RUN;
                end
            end
            default: begin
                next_state   = RUN;
                next_bub_cnt = 2'd0;
            end
        endcase
    end

`ifdef HAZ_MULDIV_EN
    localparam int BUSY_W = $clog2(MULDIV_LAT + 1);

    logic [BUSY_W-1:0] busy_cnt;

    // A new mult/div or a HI/LO read must wait while the unit is occupied.
    always_comb begin
        busy_stall = (busy_cnt != '0) && (ID_MulDiv || ID_ReadsHiLo);
    end

    // Occupancy counter: loaded when a mult/div issues, counts down to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (ID_MulDiv && !stall_any) begin
            busy_cnt <= BUSY_W'(MULDIV_LAT);
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - BUSY_W'(1);
        end
    end
`else
    // Mult/div is single-cycle here, so it never holds the pipeline.
    always_comb begin
        busy_stall = 1'b0;
    end
`endif

    // Pipeline control; reset forces everything inactive, stall beats flush.
    always_comb begin
        stall_any  = fsm_stall || busy_stall;
        PCWrite    = 1'b1;
        IF_IDWrite = 1'b1;
        IF_IDFlush = 1'b0;
        ID_ExFlush = 1'b0;
        if (!rst) begin
            if (stall_any) begin
                PCWrite    = 1'b0;
                IF_IDWrite = 1'b0;
                ID_ExFlush = 1'b1;
            end else if (BranchTaken) begin
                IF_IDFlush = 1'b1;
            end
        end
    end

    // Saturating count of stall cycles for performance monitoring.
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCycles <= '0;
        end else if (stall_any && (StallCycles != {CNT_W{1'b1}})) begin
            StallCycles <= StallCycles + CNT_W'(1);
        end
    end

endmodule
